// File: rtl/ir_queue_if.sv
// ir_queue_if: handshake and decode bundle for the instruction queue.
//   Producer side : in_valid, in_ready, in_instr, in_pc
//   Consumer side : out_valid, out_ready, out_instr, out_pc
//   Decoded head  : funct3, funct7, opcode, rs1, rs2, rd,
//                   i/s/b/u/j immediates, illegal
// Modports:
//   master - the environment (fetch unit and control/datapath)
//   slave  - the queue itself
interface ir_queue_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [31:0]     i_imm;
  logic [31:0]     s_imm;
  logic [31:0]     b_imm;
  logic [31:0]     u_imm;
  logic [31:0]     j_imm;
  logic            illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  funct3, funct7, opcode, rs1, rs2, rd,
    input  i_imm, s_imm, b_imm, u_imm, j_imm, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output funct3, funct7, opcode, rs1, rs2, rd,
    output i_imm, s_imm, b_imm, u_imm, j_imm, illegal
  );
endinterface

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction queue that replaces the single IR.
// Each entry holds an instruction word and its PC. The head entry is
// presented fully decoded (fields, immediates, illegal-opcode flag).
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   flush - synchronous discard of all entries (redirect)
//   q     - ir_queue_if.slave: in/out handshakes and decoded head
//   count - current occupancy, 0..DEPTH
module ir_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ir_queue_if.slave              q,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // RV32I base opcodes
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      instr_w [DEPTH];
  logic [PC_W-1:0]  pc_w    [DEPTH];

  logic             enq;
  logic             deq;

  // Handshake status comes only from registered state, so there is no
  // combinational path from the input side to either ready or valid.
  assign q.in_ready  = (count_q != CNT_W'(DEPTH));
  assign q.out_valid = (count_q != '0);
  assign count       = count_q;

  // No full-bypass: a full queue refuses input even while draining.
  assign enq = q.in_valid && q.in_ready;
  assign deq = q.out_valid && q.out_ready;

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage slots. Each slot is its own register so the whole queue can be
  // cleared by the asynchronous reset; a flushed enqueue is not written.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic            slot_we;
      logic [31:0]     slot_instr_q;
      logic [PC_W-1:0] slot_pc_q;

      assign slot_we = enq && !flush && (tail_q == PTR_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_instr_q <= '0;
          slot_pc_q    <= '0;
        end else if (slot_we) begin
          slot_instr_q <= q.in_instr;
          slot_pc_q    <= q.in_pc;
        end
      end

      assign instr_w[gi] = slot_instr_q;
      assign pc_w[gi]    = slot_pc_q;
    end
  endgenerate

  // Head decode. The head word is masked to zero when the queue is empty,
  // which forces every field and immediate to zero as well.
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  logic            legal;

  always_comb begin
    head_instr = '0;
    head_pc    = '0;
    if (q.out_valid) begin
      head_instr = instr_w[head_q];
      head_pc    = pc_w[head_q];
    end
  end

  always_comb begin
    legal = 1'b0;
    case (head_instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_CSR: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
  end

  assign q.out_instr = head_instr;
  assign q.out_pc    = head_pc;
  assign q.funct3    = head_instr[14:12];
  assign q.funct7    = head_instr[31:25];
  assign q.opcode    = head_instr[6:0];
  assign q.rs1       = head_instr[19:15];
  assign q.rs2       = head_instr[24:20];
  assign q.rd        = head_instr[11:7];
  assign q.i_imm     = {{20{head_instr[31]}}, head_instr[31:20]};
  assign q.s_imm     = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign q.b_imm     = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                        head_instr[30:25], head_instr[11:8], 1'b0};
  assign q.u_imm     = {head_instr[31:12], 12'h000};
  assign q.j_imm     = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                        head_instr[20], head_instr[30:21], 1'b0};
  assign q.illegal   = q.out_valid && !legal;

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed bench for ir_queue (DEPTH=4, PC_W=32) with a
// scoreboard of accepted entries checked against the queue head.
module tb_ir_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;

  ir_queue_if #(.PC_W(32)) bus ();

  ir_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (bus.slave),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus. Before the edge the queue state is compared with
  // the scoreboard; after the edge the scoreboard is updated with what the
  // queue should have accepted/released.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    logic enq;
    logic deq;
    ent_t e;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    chk("count", 32'(count), 32'(sb.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(sb.size() != DEPTH));
    if (sb.size() != 0) begin
      chk("head_instr", bus.out_instr, sb[0].instr);
      chk("head_pc", bus.out_pc, sb[0].pc);
    end else begin
      chk("idle_instr", bus.out_instr, 32'h0);
      chk("idle_illegal", 32'(bus.illegal), 32'h0);
    end
    enq = iv && (sb.size() != DEPTH);
    deq = ordy && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      $display("flush: queue emptied");
    end else begin
      if (deq) begin
        e = sb.pop_front();
        $display("deq pc=%h instr=%h", e.pc, e.instr);
      end
      if (enq) begin
        e.instr = ins;
        e.pc    = pc;
        sb.push_back(e);
        $display("enq pc=%h instr=%h", pc, ins);
      end
    end
  endtask

  initial begin
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_illegal", 32'(bus.illegal), 32'h0);
    chk("rst_i_imm", bus.i_imm, 32'h0);
    chk("rst_u_imm", bus.u_imm, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);   // dequeue on empty is ignored

    // addi x1,x0,10
    cycle(1'b1, 32'h00A00093, 32'h60, 1'b0, 1'b0);
    chk("addi_valid", 32'(bus.out_valid), 32'h1);
    chk("addi_opcode", 32'(bus.opcode), 32'h13);
    chk("addi_rd", 32'(bus.rd), 32'h1);
    chk("addi_rs1", 32'(bus.rs1), 32'h0);
    chk("addi_funct3", 32'(bus.funct3), 32'h0);
    chk("addi_i_imm", bus.i_imm, 32'h0000000A);
    chk("addi_pc", bus.out_pc, 32'h60);
    chk("addi_illegal", 32'(bus.illegal), 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // beq offset -4
    cycle(1'b1, 32'hFE000EE3, 32'h64, 1'b0, 1'b0);
    chk("beq_opcode", 32'(bus.opcode), 32'h63);
    chk("beq_b_imm", bus.b_imm, 32'hFFFFFFFC);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // jal
    cycle(1'b1, 32'h800000EF, 32'h68, 1'b0, 1'b0);
    chk("jal_rd", 32'(bus.rd), 32'h1);
    chk("jal_j_imm", bus.j_imm, 32'hFFF00000);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // lui
    cycle(1'b1, 32'h123450B7, 32'h6C, 1'b0, 1'b0);
    chk("lui_u_imm", bus.u_imm, 32'h12345000);
    chk("lui_rd", 32'(bus.rd), 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // sw x2,8(x1): s_imm
    cycle(1'b1, 32'h0020A423, 32'h70, 1'b0, 1'b0);
    chk("sw_s_imm", bus.s_imm, 32'h00000008);
    chk("sw_rs2", 32'(bus.rs2), 32'h2);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to DEPTH, refuse a fifth, then full with in_valid and out_ready
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h00000013 + (32'(i) << 20), 32'h100 + 32'(i) * 4, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'h4);
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    cycle(1'b1, 32'hDEAD0013, 32'h1F0, 1'b0, 1'b0);
    cycle(1'b1, 32'hBEEF0013, 32'h1F4, 1'b1, 1'b0);
    chk("full_deq_count", 32'(count), 32'h3);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Steady stream: pointers wrap, occupancy settles at 1
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h00100093 + (32'(i) << 20), 32'(i) * 4, 1'b1, 1'b0);
    chk("stream_count", 32'(count), 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h00000033 + (32'(i) << 7), 32'h200 + 32'(i) * 4, 1'b0, 1'b0);
    cycle(1'b1, 32'hCAFE0013, 32'h2F0, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'h0);

    // Undefined opcode
    cycle(1'b1, 32'h0000007F, 32'h300, 1'b0, 1'b0);
    chk("illegal_set", 32'(bus.illegal), 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("illegal_clear", 32'(bus.illegal), 32'h0);

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h00000013, 32'h400 + 32'(i) * 4, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("async_rst_out_pc", bus.out_pc, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Cycle budget guard
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
